// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Used by the single-stage counter and by cascades built from it (BCD digits, mod-60 timers).
package mod_n_updown_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Terminal value of a modulo-m counter: the last state before wrapping.
   function automatic int unsigned term_of(input int unsigned modulus);
      return modulus - 1;
   endfunction

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for one counter stage.
// The master drives the controls; the counter stage is the slave.
interface mod_n_updown_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             preset;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrapped;

   modport master (
      output en, up, load, load_val, preset,
      input  count, tc, wrapped
   );

   modport slave (
      input  en, up, load, load_val, preset,
      output count, tc, wrapped
   );
endinterface

// File: rtl/mod_n_updown_counter_next.sv
// Combinational next-count and wrap-flag logic for a modulo-N up/down step.
// Out-of-range counts recover to 0 (up) or MODULUS-1 (down) without flagging a wrap.
module mod_n_updown_counter_next
   import mod_n_updown_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   output logic [WIDTH-1:0] next,
   output logic             wrap
);
   // One extra bit so MODULUS == 2**WIDTH compares correctly.
   localparam logic [WIDTH:0] TERM = (WIDTH+1)'(term_of(MODULUS));

   logic [WIDTH:0] c_ext;
   logic [WIDTH:0] nxt_ext;

   assign c_ext = {1'b0, count};

   always_comb begin
      nxt_ext = '0;
      wrap    = 1'b0;
      if (up == DIR_UP) begin
         if (c_ext >= TERM) begin
            nxt_ext = '0;
            wrap    = (c_ext == TERM);
         end else begin
            nxt_ext = c_ext + 1'b1;
         end
      end else begin
         if (c_ext == '0) begin
            nxt_ext = TERM;
            wrap    = 1'b1;
         end else if (c_ext > TERM) begin
            nxt_ext = TERM;
         end else begin
            nxt_ext = c_ext - 1'b1;
         end
      end
   end

   assign next = WIDTH'(nxt_ext);

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with load, preset, combinational carry/borrow (tc) and a wrap pulse.
// Stages chain by feeding one stage's tc into the next stage's en.
module mod_n_updown_counter
   import mod_n_updown_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic                  clk,
   input  logic                  clear,
   mod_n_updown_counter_if.slave bus
);
   localparam logic [WIDTH:0]   TERM_EXT = (WIDTH+1)'(term_of(MODULUS));
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TERM     = WIDTH'(TERM_EXT);

   logic [WIDTH-1:0] count_q;
   logic             wrapped_q;
   logic [WIDTH-1:0] step_val;
   logic             step_wrap;

   mod_n_updown_counter_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count (count_q),
      .up    (bus.up),
      .next  (step_val),
      .wrap  (step_wrap)
   );

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else if (bus.load) begin
         count_q   <= ({1'b0, bus.load_val} >= MOD_EXT) ? TERM : bus.load_val;
         wrapped_q <= 1'b0;
      end else if (bus.preset) begin
         count_q   <= TERM;
         wrapped_q <= 1'b0;
      end else if (bus.en) begin
         count_q   <= step_val;
         wrapped_q <= step_wrap;
      end else begin
         wrapped_q <= 1'b0;
      end
   end

   // Carry/borrow is combinational so the next stage steps on the same edge.
   assign bus.tc = clear & bus.en &
                   ((bus.up & ({1'b0, count_q} == TERM_EXT)) |
                    (~bus.up & (count_q == '0)));

   assign bus.count   = count_q;
   assign bus.wrapped = wrapped_q;

endmodule
